// File: rtl/idex_bundle_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register.
// Holds the decode bundle geometry (bit positions of every field inside the
// 72-bit decode_out bundle) so that the decoder's packing and every consumer's
// unpacking agree on one layout, plus the regfile write-source encodings.
package idex_bundle_reg_pkg;

  localparam int unsigned DEC_W = 72;
  localparam int unsigned PC_W  = 32;

  // Field positions inside the decode bundle, MSB first.
  localparam int unsigned DEC_INST_TYPE_HI = 71;
  localparam int unsigned DEC_INST_TYPE_LO = 69;
  localparam int unsigned DEC_RS_HI        = 68;
  localparam int unsigned DEC_RS_LO        = 64;
  localparam int unsigned DEC_RT_HI        = 63;
  localparam int unsigned DEC_RT_LO        = 59;
  localparam int unsigned DEC_RD_HI        = 58;
  localparam int unsigned DEC_RD_LO        = 54;
  localparam int unsigned DEC_IMM_HI       = 53;
  localparam int unsigned DEC_IMM_LO       = 22;
  localparam int unsigned DEC_EXT_OP_HI    = 21;
  localparam int unsigned DEC_EXT_OP_LO    = 16;
  localparam int unsigned DEC_NPC_OP_HI    = 15;
  localparam int unsigned DEC_NPC_OP_LO    = 13;
  localparam int unsigned DEC_ALU_SRC      = 12;
  localparam int unsigned DEC_ALU_OP_HI    = 11;
  localparam int unsigned DEC_ALU_OP_LO    = 7;
  localparam int unsigned DEC_DM_WE        = 6;
  localparam int unsigned DEC_DM_SIGN      = 5;
  localparam int unsigned DEC_DM_WIDTH_HI  = 4;
  localparam int unsigned DEC_DM_WIDTH_LO  = 3;
  localparam int unsigned DEC_RF_WE        = 2;
  localparam int unsigned DEC_RF_WSRC_HI   = 1;
  localparam int unsigned DEC_RF_WSRC_LO   = 0;

  // Regfile write source: value comes from data memory (i.e. a load).
  localparam logic [1:0] RF_WSRC_DM = 2'b01;

endpackage

// File: rtl/idex_bundle_reg_decode_unpack.sv
// decode_unpack: purely combinational split of a decode bundle into named
// execute-stage fields. No gating happens here; callers that need bubbles to
// be harmless qualify the write enables themselves.
//   bundle     in  72  packed decode bundle
//   inst_type  out  3  ... rf_wsrc out 2   named fields (see package positions)
module decode_unpack
  import idex_bundle_reg_pkg::*;
(
  input  logic [DEC_W-1:0] bundle,
  output logic [2:0]       inst_type,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       rd_addr,
  output logic [31:0]      imm,
  output logic [5:0]       ext_op,
  output logic [2:0]       npc_op,
  output logic             alu_src,
  output logic [4:0]       alu_op,
  output logic             dm_we,
  output logic             dm_sign,
  output logic [1:0]       dm_width,
  output logic             rf_we,
  output logic [1:0]       rf_wsrc
);

  assign inst_type = bundle[DEC_INST_TYPE_HI:DEC_INST_TYPE_LO];
  assign rs_addr   = bundle[DEC_RS_HI:DEC_RS_LO];
  assign rt_addr   = bundle[DEC_RT_HI:DEC_RT_LO];
  assign rd_addr   = bundle[DEC_RD_HI:DEC_RD_LO];
  assign imm       = bundle[DEC_IMM_HI:DEC_IMM_LO];
  assign ext_op    = bundle[DEC_EXT_OP_HI:DEC_EXT_OP_LO];
  assign npc_op    = bundle[DEC_NPC_OP_HI:DEC_NPC_OP_LO];
  assign alu_src   = bundle[DEC_ALU_SRC];
  assign alu_op    = bundle[DEC_ALU_OP_HI:DEC_ALU_OP_LO];
  assign dm_we     = bundle[DEC_DM_WE];
  assign dm_sign   = bundle[DEC_DM_SIGN];
  assign dm_width  = bundle[DEC_DM_WIDTH_HI:DEC_DM_WIDTH_LO];
  assign rf_we     = bundle[DEC_RF_WE];
  assign rf_wsrc   = bundle[DEC_RF_WSRC_HI:DEC_RF_WSRC_LO];

endmodule

// File: rtl/idex_bundle_reg.sv
// idex_bundle_reg: ID/EX pipeline register with a 2-entry skid (main M, skid S).
// Accepts decode bundle + PC under valid/ready, presents M to execute as named
// fields, supports flush, and reports load-use hazards against decode_in.
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready, decode_in[71:0], pc_in[31:0]      decode side
//   out_valid/out_ready, pc_out[31:0], unpacked fields     execute side
//   lu_hazard                                              advisory to hazard unit
module idex_bundle_reg
  import idex_bundle_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEC_W-1:0] decode_in,
  input  logic [PC_W-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  pc_out,
  output logic [2:0]       inst_type,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       rd_addr,
  output logic [31:0]      imm,
  output logic [5:0]       ext_op,
  output logic [2:0]       npc_op,
  output logic             alu_src,
  output logic [4:0]       alu_op,
  output logic             dm_we,
  output logic             dm_sign,
  output logic [1:0]       dm_width,
  output logic             rf_we,
  output logic [1:0]       rf_wsrc,
  output logic             lu_hazard
);

  logic             m_valid;
  logic             s_valid;
  logic [DEC_W-1:0] m_bundle;
  logic [DEC_W-1:0] s_bundle;
  logic [PC_W-1:0]  m_pc;
  logic [PC_W-1:0]  s_pc;
  logic             acc;
  logic             pop;
  logic             dm_we_raw;
  logic             rf_we_raw;

  // Ready depends only on registered occupancy so execute-side backpressure
  // never forms a combinational path back into decode.
  assign in_ready  = !s_valid && !rst;
  assign out_valid = m_valid;
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      m_bundle <= '0;
      s_bundle <= '0;
      m_pc     <= '0;
      s_pc     <= '0;
    end else if (flush) begin
      // A beat accepted this cycle is dropped along with everything buffered.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid) begin
      if (acc) begin
        m_valid  <= 1'b1;
        m_bundle <= decode_in;
        m_pc     <= pc_in;
      end
    end else if (pop) begin
      if (s_valid) begin
        // in_ready was low, so nothing new can arrive while S drains.
        m_bundle <= s_bundle;
        m_pc     <= s_pc;
        s_valid  <= 1'b0;
      end else if (acc) begin
        m_bundle <= decode_in;
        m_pc     <= pc_in;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (acc) begin
      s_valid  <= 1'b1;
      s_bundle <= decode_in;
      s_pc     <= pc_in;
    end
  end

  decode_unpack u_unpack (
    .bundle    (m_bundle),
    .inst_type (inst_type),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .imm       (imm),
    .ext_op    (ext_op),
    .npc_op    (npc_op),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .dm_we     (dm_we_raw),
    .dm_sign   (dm_sign),
    .dm_width  (dm_width),
    .rf_we     (rf_we_raw),
    .rf_wsrc   (rf_wsrc)
  );

  assign pc_out = m_pc;
  // Only the side-effecting enables are qualified; a bubble must never write.
  assign dm_we  = dm_we_raw && m_valid;
  assign rf_we  = rf_we_raw && m_valid;

  assign lu_hazard = rf_we && (rf_wsrc == RF_WSRC_DM) && (rd_addr != 5'd0) && in_valid &&
                     ((decode_in[DEC_RS_HI:DEC_RS_LO] == rd_addr) ||
                      (decode_in[DEC_RT_HI:DEC_RT_LO] == rd_addr));

endmodule
